riscv_bus_mem: RTL and testbench
================================

Name: riscv_bus_mem

Overview:
Single-port word memory that acts as the responder for the core's instruction bus (iBus) and data bus (dBus). It arbitrates between the two command ports and performs one access per transaction. Each access gets a one-cycle response pulse. It sits beside the riscv core in simulation and FPGA tops as the program/data store.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two.
AW, $clog2(DEPTH), word-index width; derived, not overridden.
WAIT_CYCLES, 0, extra cycles inserted before cmd_ready on every transaction (0..15).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
iBus_cmd_valid  in  1  fetch request.
iBus_cmd_ready  out  1  fetch accepted this cycle.
iBus_cmd_payload_pc  in  32  fetch byte address.
iBus_rsp_ready  out  1  one-cycle fetch response strobe.
iBus_rsp_err  out  1  fetch error; qualified by iBus_rsp_ready.
iBus_rsp_inst  out  32  fetched word; qualified by iBus_rsp_ready.
dBus_cmd_valid  in  1  data request.
dBus_cmd_ready  out  1  data request accepted this cycle.
dBus_cmd_payload_wr  in  1  1 = store, 0 = load.
dBus_cmd_payload_address  in  32  data byte address.
dBus_cmd_payload_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
dBus_cmd_payload_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
dBus_rsp_ready  out  1  one-cycle data response strobe.
dBus_rsp_err  out  1  data error; qualified by dBus_rsp_ready.
dBus_rsp_data  out  32  aligned word read; 0 for stores/errors.

Behaviour:
- Reset (rst high at posedge):
  - FSM goes to IDLE, wait counter to 0, grant to none.
  - All rsp outputs are 0; cmd_ready outputs are 0 during reset.
  - Memory contents are not reset.
  - A handshake coincident with rst is discarded: no write, no response.
- FSM states IDLE, WAIT, RESP.
  - IDLE: if dBus_cmd_valid, grant dBus; else if iBus_cmd_valid, grant iBus. dBus has fixed priority.
    - WAIT_CYCLES=0: the granted cmd_ready is asserted combinationally in the same cycle; the handshake occurs; next state is RESP.
    - Otherwise load the counter with WAIT_CYCLES and go to WAIT.
  - WAIT: the grant is frozen; a newly rising valid on the other port is ignored. The counter decrements each cycle.
    - When the counter reaches 0, the granted cmd_ready is asserted for exactly that cycle; handshake; go to RESP.
    - If the granted valid deasserts while in WAIT (initiator violation), return to IDLE with no access and no response.
  - RESP: the granted port's rsp_ready is high for exactly one cycle with its err/data; next state is IDLE.
- Latency and throughput:
  - Response appears the cycle after the handshake.
  - Minimum spacing is one transaction per 2 + WAIT_CYCLES cycles.
  - At most one cmd_ready is high in any cycle; never both.
- iBus access:
  - Word index is pc[AW+1:2].
  - iBus_rsp_err=1 if pc[1:0]!=0 or pc[31:2]>=DEPTH. On error, iBus_rsp_inst=32'h00000013 (NOP).
- dBus access:
  - Word index is address[AW+1:2].
  - dBus_rsp_err=1 on any of: size==3; size==1 with address[0]!=0; size==2 with address[1:0]!=0; address[31:2]>=DEPTH.
  - An erroring store writes nothing.
  - Store byte: data[7:0] goes to lane address[1:0].
  - Store half: data[15:0] goes to lanes {address[1],0}+1:{address[1],0}.
  - Store word: all four lanes are written.
  - Unselected lanes are unchanged. The write takes effect at the handshake edge.
  - Load: dBus_rsp_data is the full aligned word read at the handshake edge. The core performs lane extraction and extension.
- Ordering: a load issued after a store to the same word returns the stored data (read-after-write through the array).
- Response outputs return to 0 in every non-RESP cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with both valids high → all cmd_ready and rsp outputs 0; after release, first grant goes to dBus.
- Fetch, WAIT_CYCLES=0: preload word 4 = 32'hDEADBEEF; iBus pc=0x10 → iBus_cmd_ready in the same cycle, iBus_rsp_ready next cycle, inst=DEADBEEF, err=0.
- Byte/half stores: word 2 = 0; sb 0xAA to 0x09; sh 0x1234 to 0x0A; lw 0x08 → rsp_data=32'h1234AA00.
- Errors:
  - Fetch pc=0x02 → err=1, inst=00000013.
  - sh to 0x0B → err=1 and memory unchanged.
  - size=3 → err=1.
  - Address 4*DEPTH → err=1.
- Contention with WAIT_CYCLES=2: both valids rise together → dBus_cmd_ready 2 cycles later, dBus response, then iBus served; iBus_cmd_ready never coincides with dBus_cmd_ready.
- Abort and mid-op reset:
  - dBus valid dropped during WAIT → no response, FSM back to IDLE.
  - rst asserted in the handshake cycle of a store → no write and no rsp pulse.

Source files
------------

// File: rtl/riscv_bus_mem.sv
// riscv_bus_mem: single-port word memory answering the core's iBus and dBus, dBus first.
module riscv_bus_mem #(
    parameter int DEPTH = 1024,
    parameter int WAIT_CYCLES = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iBus_cmd_valid,
    output logic        iBus_cmd_ready,
    input  logic [31:0] iBus_cmd_payload_pc,
    output logic        iBus_rsp_ready,
    output logic        iBus_rsp_err,
    output logic [31:0] iBus_rsp_inst,
    input  logic        dBus_cmd_valid,
    output logic        dBus_cmd_ready,
    input  logic        dBus_cmd_payload_wr,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [1:0]  dBus_cmd_payload_size,
    output logic        dBus_rsp_ready,
    output logic        dBus_rsp_err,
    output logic [31:0] dBus_rsp_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic sel, valid, ready, hs, oor, i_err, d_err, err, we, rsp_i, rsp_d;
    logic [31:0] addr, rdata, wdata, data_q;
    logic err_q;
    logic [AW-1:0] idx;
    logic [3:0] be;
    logic [31:0] mem_q [DEPTH];
    // In IDLE the grant is decided live; afterwards it stays frozen until IDLE again.
    assign sel = (state_q == IDLE) ? dBus_cmd_valid : gnt_q;
    assign valid = sel ? dBus_cmd_valid : iBus_cmd_valid;
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        ready = 1'b0;
        if (state_q == IDLE) begin
            gnt_d = sel;
            cnt_d = 4'(WAIT_CYCLES);
            if (valid) begin
                ready = (WAIT_CYCLES == 0);
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (!valid) state_d = IDLE;
            else if (cnt_q == 4'd1) begin
                ready = 1'b1;
                state_d = RESP;
            end
        end else state_d = IDLE;
    end
    assign hs = ready & ~rst;
    assign iBus_cmd_ready = hs & ~sel;
    assign dBus_cmd_ready = hs & sel;
    assign addr = sel ? dBus_cmd_payload_address : iBus_cmd_payload_pc;
    assign idx = addr[AW+1:2];
    assign oor = addr[31:AW+2] != '0;
    assign i_err = (addr[1:0] != 2'b00) | oor;
    assign d_err = (dBus_cmd_payload_size == 2'd3) | (dBus_cmd_payload_size == 2'd1 & addr[0]) |
                   (dBus_cmd_payload_size == 2'd2 & addr[1:0] != 2'b00) | oor;
    assign err = sel ? d_err : i_err;
    assign rdata = sel ? ((d_err | dBus_cmd_payload_wr) ? 32'h0 : mem_q[idx]) : (i_err ? 32'h00000013 : mem_q[idx]);
    assign we = dBus_cmd_ready & dBus_cmd_payload_wr & ~d_err;
    assign be = (dBus_cmd_payload_size == 2'd0) ? 4'b0001 << addr[1:0] :
                (dBus_cmd_payload_size == 2'd1) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = (dBus_cmd_payload_size == 2'd0) ? {4{dBus_cmd_payload_data[7:0]}} :
                   (dBus_cmd_payload_size == 2'd1) ? {2{dBus_cmd_payload_data[15:0]}} : dBus_cmd_payload_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= 1'b0;
            cnt_q <= 4'd0;
            err_q <= 1'b0;
            data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            if (hs) begin
                err_q <= err;
                data_q <= rdata;
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    assign rsp_i = (state_q == RESP) & ~gnt_q & ~rst;
    assign rsp_d = (state_q == RESP) & gnt_q & ~rst;
    assign iBus_rsp_ready = rsp_i;
    assign iBus_rsp_err = rsp_i & err_q;
    assign iBus_rsp_inst = rsp_i ? data_q : 32'h0;
    assign dBus_rsp_ready = rsp_d;
    assign dBus_rsp_err = rsp_d & err_q;
    assign dBus_rsp_data = rsp_d ? data_q : 32'h0;
endmodule

// File: tb/tb_riscv_bus_mem.sv
// tb_riscv_bus_mem: random and directed traffic on two instances (WAIT_CYCLES 0 and 2) against a word-array model.
module tb_riscv_bus_mem;
    localparam int D = 64;
    logic clk = 1'b0;
    logic rst;
    logic iv[2], ir[2], irr[2], ie[2], dv[2], dr[2], dwr[2], drr[2], de[2];
    logic [31:0] ipc[2], ii[2], da[2], dd[2], drd[2];
    logic [1:0] ds[2];
    logic [31:0] m[2][D];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        riscv_bus_mem #(.DEPTH(D), .WAIT_CYCLES(2*g)) u (
            .clk(clk), .rst(rst),
            .iBus_cmd_valid(iv[g]), .iBus_cmd_ready(ir[g]), .iBus_cmd_payload_pc(ipc[g]),
            .iBus_rsp_ready(irr[g]), .iBus_rsp_err(ie[g]), .iBus_rsp_inst(ii[g]),
            .dBus_cmd_valid(dv[g]), .dBus_cmd_ready(dr[g]), .dBus_cmd_payload_wr(dwr[g]),
            .dBus_cmd_payload_address(da[g]), .dBus_cmd_payload_data(dd[g]), .dBus_cmd_payload_size(ds[g]),
            .dBus_rsp_ready(drr[g]), .dBus_rsp_err(de[g]), .dBus_rsp_data(drd[g])
        );
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic op(input int k, input bit isd, input bit wr, input logic [31:0] a,
                      input logic [31:0] dat, input logic [1:0] sz, output logic [31:0] got);
        bit ee, hit;
        logic [31:0] ed;
        int n, wc;
        wc = 2 * k;
        if (isd) begin
            ee = sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || a / 4 >= D;
            ed = (wr || ee) ? 32'h0 : m[k][a/4];
            dv[k] = 1; dwr[k] = wr; da[k] = a; dd[k] = dat; ds[k] = sz;
        end else begin
            ee = a % 4 != 0 || a / 4 >= D;
            ed = ee ? 32'h00000013 : m[k][a/4];
            iv[k] = 1; ipc[k] = a;
        end
        n = 0;
        hit = 0;
        while (!hit && n <= 20) begin
            @(negedge clk);
            check("other_rdy", isd ? ir[k] : dr[k], 0);
            if (isd ? dr[k] : ir[k]) hit = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("latency", n, wc);
        @(posedge clk); #1;
        dv[k] = 0; iv[k] = 0;
        @(negedge clk);
        if (isd) begin
            check("d_rsp", drr[k], 1); check("d_err", de[k], ee); check("d_data", drd[k], ed);
            check("i_rsp_quiet", irr[k], 0);
            got = drd[k];
        end else begin
            check("i_rsp", irr[k], 1); check("i_err", ie[k], ee); check("i_inst", ii[k], ed);
            check("d_rsp_quiet", drr[k], 0);
            got = ii[k];
        end
        @(posedge clk); #1;
        if (isd && wr && !ee) begin
            if (sz == 0) m[k][a/4][8*(a%4) +: 8] = dat[7:0];
            else if (sz == 1) m[k][a/4][8*(a%4) +: 16] = dat[15:0];
            else m[k][a/4] = dat;
        end
    endtask
    task automatic contend(input int k);
        int cdr = -1, cdrr = -1, cir = -1, cirr = -1, wc;
        wc = 2 * k;
        ipc[k] = 32'h10; iv[k] = 1;
        da[k] = 32'h10; dwr[k] = 0; ds[k] = 2; dv[k] = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("both_rdy", dr[k] & ir[k], 0);
            if (dr[k] && cdr < 0) cdr = c;
            if (ir[k] && cir < 0) cir = c;
            if (drr[k]) begin cdrr = c; check("c_ddata", drd[k], m[k][4]); end
            if (irr[k]) begin cirr = c; check("c_inst", ii[k], m[k][4]); end
            @(posedge clk); #1;
            if (cdr >= 0) dv[k] = 0;
            if (cir >= 0) iv[k] = 0;
        end
        check("c_dreq", cdr, wc); check("c_drsp", cdrr, wc + 1);
        check("c_ireq", cir, 2 * wc + 2); check("c_irsp", cirr, 2 * wc + 3);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic [31:0] got, a;
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1; ipc[k] = 0; dv[k] = 1; dwr[k] = 0; da[k] = 0; dd[k] = 0; ds[k] = 2;
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check("rst_outs", {dr[k], ir[k], drr[k], irr[k], de[k], ie[k]} | drd[k] | ii[k], 0);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_grant_d", dr[0], 1); check("rst_grant_i", ir[0], 0);
        check("rst_w2_rdy", dr[1] | ir[1], 0);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin iv[k] = 0; dv[k] = 0; end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < D; w++) op(k, 1, 1, 32'(w * 4), $urandom, 2, got);
        for (int k = 0; k < 2; k++) begin
            op(k, 1, 1, 32'h10, 32'hDEADBEEF, 2, got);
            op(k, 0, 0, 32'h10, 0, 0, got);
            check("fetch", got, 32'hDEADBEEF);
            op(k, 1, 1, 32'h08, 0, 2, got);
            op(k, 1, 1, 32'h09, 32'h000000AA, 0, got);
            op(k, 1, 1, 32'h0A, 32'h00001234, 1, got);
            op(k, 1, 0, 32'h08, 0, 2, got);
            check("sbsh", got, 32'h1234AA00);
            op(k, 0, 0, 32'h02, 0, 0, got);
            op(k, 1, 1, 32'h0B, 32'h5555, 1, got);
            op(k, 1, 0, 32'h08, 0, 2, got);
            check("sh_err_keep", got, 32'h1234AA00);
            op(k, 1, 0, 32'h08, 0, 3, got);
            op(k, 1, 0, 32'(4 * D), 0, 2, got);
            op(k, 0, 0, 32'(4 * D), 0, 0, got);
            contend(k);
        end
        dv[1] = 1; dwr[1] = 0; da[1] = 32'h10; ds[1] = 2;
        @(posedge clk); #1;
        dv[1] = 0;
        repeat (5) begin
            @(negedge clk);
            check("abort_quiet", {dr[1], drr[1]}, 0);
        end
        @(posedge clk); #1;
        op(1, 0, 0, 32'h10, 0, 0, got);
        for (int k = 0; k < 2; k++) begin
            dv[k] = 1; dwr[k] = 1; da[k] = 32'h20; dd[k] = ~m[k][8]; ds[k] = 2;
            repeat (2 * k) begin @(posedge clk); #1; end
            rst = 1;
            @(negedge clk);
            check("rst_hs_rdy", dr[k], 0);
            @(posedge clk); #1;
            rst = 0; dv[k] = 0;
            repeat (3) begin
                @(negedge clk);
                check("rst_hs_rsp", drr[k], 0);
            end
            @(posedge clk); #1;
            op(k, 1, 0, 32'h20, 0, 2, got);
        end
        for (int i = 0; i < 500; i++) begin
            a = $urandom_range(0, 4 * D + 8);
            if ($urandom % 4 != 0) a = a & ~32'h3;
            op(i % 2, 1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), got);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
